// File: rtl/sa_weight_load_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// sa_ctrl_pkg
// Shared constants for the systolic-array weight load controller:
//   - tile geometry (3x3 tile, 9 weights)
//   - issue counter and weight-memory address widths
//   - FSM state encodings (also exposed on the controller's debug port)
// ----------------------------------------------------------------------------
package sa_ctrl_pkg;

    localparam int TILE_DIM = 3;
    localparam int TILE_N_W = TILE_DIM * TILE_DIM;

    localparam int CNT_W  = 4;
    localparam int ADDR_W = 6;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/sa_weight_load_ctrl_if.sv
// ----------------------------------------------------------------------------
// sa_weight_load_ctrl_if
// Bundles the controller's request, weight-memory and array-side signals.
//
//   start      request to load one tile (honoured only while idle)
//   base_addr  tile base address, captured when start is honoured
//   sa_ready   array flow control
//   mem_rd_en  weight memory read strobe
//   mem_addr   weight memory read address
//   mem_rdata  weight memory read data (one cycle after mem_rd_en)
//   w_valid    w_data / w_idx valid towards the array
//   w_data     weight word
//   w_idx      issue ordinal 0..8 of the presented word
//   busy       tile in progress
//   done       one-cycle completion pulse
//
// Handshake: sa_ready is a look-ahead permit. When sa_ready=1 in cycle N the
// controller may read memory in cycle N, and the array is then obliged to
// accept the word presented (w_valid=1) in cycle N+1. There is no back
// pressure on w_valid itself; stalls happen only on the read side.
//
// Modports: slave = controller side, master = environment side.
// ----------------------------------------------------------------------------
interface sa_weight_load_ctrl_if #(
    parameter int DATA_W = 8
);
    import sa_ctrl_pkg::*;

    logic                 start;
    logic [ADDR_W-1:0]    base_addr;
    logic                 sa_ready;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_rdata;
    logic                 w_valid;
    logic [DATA_W-1:0]    w_data;
    logic [CNT_W-1:0]     w_idx;
    logic                 busy;
    logic                 done;

    modport slave (
        input  start, base_addr, sa_ready, mem_rdata,
        output mem_rd_en, mem_addr, w_valid, w_data, w_idx, busy, done
    );

    modport master (
        output start, base_addr, sa_ready, mem_rdata,
        input  mem_rd_en, mem_addr, w_valid, w_data, w_idx, busy, done
    );

endinterface

// File: rtl/sa_weight_load_ctrl_addr_map.sv
// ----------------------------------------------------------------------------
// sa_weight_addr_map
// Combinational issue-count to tile-offset map. Weights are stored row-major
// but the array wants them column-major, so issue k reads offset
// TILE_DIM*(k mod TILE_DIM) + k/TILE_DIM: 0,3,6,1,4,7,2,5,8.
//
//   cnt_i     issue counter (0..8 meaningful)
//   offset_o  offset within the tile
// ----------------------------------------------------------------------------
module sa_weight_addr_map
    import sa_ctrl_pkg::*;
(
    input  logic [CNT_W-1:0]  cnt_i,
    output logic [ADDR_W-1:0] offset_o
);

    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;

    always_comb begin
        col      = cnt_i % CNT_W'(TILE_DIM);
        row      = cnt_i / CNT_W'(TILE_DIM);
        offset_o = ADDR_W'(col) * ADDR_W'(TILE_DIM) + ADDR_W'(row);
    end

endmodule

// File: rtl/sa_weight_load_ctrl.sv
// ----------------------------------------------------------------------------
// sa_weight_load_ctrl
// Loads one 3x3 weight tile from weight memory into a systolic array in
// transposed order. One start request produces nine reads (stalled by
// sa_ready), nine presented words one cycle later, then a done pulse.
//
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   bus          sa_weight_load_ctrl_if.slave (request, memory, array side)
//   state_dbg_o  current FSM state (ST_* encodings from sa_ctrl_pkg)
// ----------------------------------------------------------------------------
module sa_weight_load_ctrl
    import sa_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int N_W    = TILE_N_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    sa_weight_load_ctrl_if.slave         bus,
    output logic [1:0]                   state_dbg_o
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              w_valid_q;
    logic [CNT_W-1:0]  w_idx_q;

    logic              issue;
    logic              last_issue;
    logic [ADDR_W-1:0] offset;
    logic [DATA_W-1:0] w_data_d;

    sa_weight_addr_map u_addr_map (
        .cnt_i    (cnt_q),
        .offset_o (offset)
    );

    // A read goes out in every LOAD cycle the array grants; otherwise the
    // counter simply holds.
    assign issue      = (state_q == ST_LOAD) && bus.sa_ready;
    assign last_issue = issue && (cnt_q == CNT_W'(N_W - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    base_d  = bus.base_addr;
                end
            end
            ST_LOAD: begin
                if (issue) begin
                    cnt_d = last_issue ? '0 : cnt_q + 1'b1;
                end
                if (last_issue) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            base_q    <= '0;
            w_valid_q <= 1'b0;
            w_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            base_q    <= base_d;
            w_valid_q <= issue;
            if (issue) begin
                w_idx_q <= cnt_q;
            end
        end
    end

    // Memory data arrives exactly when w_valid is up, so it is forwarded
    // without a register; it is forced to zero otherwise so the array bus
    // stays quiet (and reads zero during reset).
    assign w_data_d = w_valid_q ? bus.mem_rdata : '0;

    assign bus.mem_rd_en = issue;
    assign bus.mem_addr  = base_q + offset;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_data    = w_data_d;
    assign bus.w_idx     = w_idx_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign state_dbg_o   = state_q;

endmodule
